// File: rtl/eb3_tx_pkg.sv
// eb3_tx_pkg: shared state encoding and default sizing for the tx_feeder frame buffer
package eb3_tx_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_SEND, ST_FINISH} state_t;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_PREAMBLE = 16;
endpackage

// File: rtl/tx_feeder_ram.sv
// tx_feeder_ram: DEPTH x 8 frame store, synchronous write port and asynchronous read port
module tx_feeder_ram #(
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/tx_feeder.sv
// tx_feeder: buffers one host frame and feeds it bytewise to a transmitter; define TX_FEEDER_RESEND_EN to allow replaying the last frame
module tx_feeder import eb3_tx_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PREAMBLE = DEF_PREAMBLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       wr_full,
  input  logic       send,
  input  logic       abort,
  input  logic       resend,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       flag_fill,
  output logic [7:0] data,
  output logic       data_available,
  input  logic       data_consumed,
  output logic       eop
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  state_t state, state_nx;
  logic [PW-1:0] wr_ptr, rd_ptr, rd_addr;
  logic [CW-1:0] count;
  logic [7:0] pcnt, rd_data;
  logic go, wr_ok, last, take_abort, consume, restart;
`ifdef TX_FEEDER_RESEND_EN
  logic fresh;
  assign go = state == ST_IDLE && count != '0 && (send || resend);
  assign restart = fresh;
  // a finished frame stays replayable until the host starts writing a new one
  always_ff @(posedge clk)
    fresh <= reset ? 1'b0 : state == ST_FINISH ? 1'b1 : wr_ok ? 1'b0 : fresh;
`else
  logic unused_resend;
  assign unused_resend = resend;
  assign go = state == ST_IDLE && count != '0 && send;
  assign restart = 1'b0;
`endif
  assign wr_full = (count == CW'(DEPTH) && !restart) || state != ST_IDLE;
  assign wr_ok = wr_en && !wr_full;
  assign last = {1'b0, rd_ptr} == count - CW'(1);
  assign take_abort = abort && (state == ST_PREAMBLE || state == ST_SEND);
  assign consume = data_consumed && state == ST_SEND && !take_abort;
  assign rd_addr = state == ST_SEND ? rd_ptr + PW'(1) : rd_ptr;
  assign busy = state != ST_IDLE;
  assign done = state == ST_FINISH;
  assign flag_fill = state == ST_PREAMBLE;
  assign data_available = state == ST_SEND;
  assign eop = state == ST_SEND && last;
  tx_feeder_ram #(.DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(wr_ok),
    .waddr(restart ? '0 : wr_ptr),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
  always_comb
    state_nx = take_abort ? ST_IDLE :
      state == ST_IDLE ? (go ? ST_PREAMBLE : ST_IDLE) :
      state == ST_PREAMBLE ? (pcnt == 8'd1 ? ST_SEND : ST_PREAMBLE) :
      state == ST_SEND ? (consume && last ? ST_FINISH : ST_SEND) : ST_IDLE;
  always_ff @(posedge clk)
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      pcnt <= '0;
      data <= '0;
      aborted <= 1'b0;
    end else begin
      state <= state_nx;
      aborted <= take_abort;
      if (take_abort) begin
        count <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok) begin
          count <= restart ? CW'(1) : count + CW'(1);
          wr_ptr <= restart ? PW'(1) : wr_ptr + PW'(1);
        end
        if (go) begin
          rd_ptr <= '0;
          pcnt <= 8'(PREAMBLE);
        end
        if (state == ST_PREAMBLE) begin
          pcnt <= pcnt - 8'd1;
          if (pcnt == 8'd1) data <= rd_data;
        end
        if (consume && !last) begin
          rd_ptr <= rd_ptr + PW'(1);
          data <= rd_data;
        end
        if (state == ST_FINISH) begin
          rd_ptr <= '0;
`ifndef TX_FEEDER_RESEND_EN
          count <= '0;
          wr_ptr <= '0;
`endif
        end
      end
    end
endmodule

// File: tb/tb_tx_feeder.sv
// tb_tx_feeder: vector table plus directed frame sequences for tx_feeder at default DEPTH/PREAMBLE
module tb_tx_feeder;
  logic clk = 1'b0;
  logic reset, wr_en, send, abort, resend, data_consumed;
  logic [7:0] wr_data, data;
  logic wr_full, busy, done, aborted, flag_fill, data_available, eop;
  logic [6:0] fl;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  assign fl = {busy, flag_fill, data_available, eop, done, aborted, wr_full};
  tx_feeder dut (
    .clk(clk),
    .reset(reset),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .wr_full(wr_full),
    .send(send),
    .abort(abort),
    .resend(resend),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .flag_fill(flag_fill),
    .data(data),
    .data_available(data_available),
    .data_consumed(data_consumed),
    .eop(eop)
  );
  typedef struct {
    logic we;
    logic [7:0] wd;
    logic snd, abt, dc;
    int n;
    logic [6:0] fl;
    logic [7:0] d;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic snd, abt, dc,
                              input int n, input logic [6:0] f, input logic [7:0] d);
    vec_t v;
    v.we = we; v.wd = wd; v.snd = snd; v.abt = abt; v.dc = dc; v.n = n; v.fl = f; v.d = d;
    return v;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic pulse_send();
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask
  task automatic wait_avail();
    for (int k = 0; k < 40 && !data_available; k++) tick();
    chk("preamble_end", data_available, 1);
  endtask
  task automatic play(input int n, input logic [7:0] base);
    wait_avail();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("byte%0d", i), data, base + 8'(i));
      chk($sformatf("eop%0d", i), eop, i == n - 1);
      data_consumed = 1'b1;
      tick();
      data_consumed = 1'b0;
    end
    chk("done_busy_avail", {done, busy, data_available}, 3'b110);
    tick();
    chk("idle_after_done", {busy, done}, 0);
  endtask
  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; send = 1'b0; abort = 1'b0;
    resend = 1'b0; data_consumed = 1'b0;
    tick();
    tick();
    chk("reset_flags", fl, 0);
    chk("reset_data", data, 0);
    reset = 1'b0;
    tv.push_back(mk(1, 8'h53, 0, 0, 0, 1, 7'b0000000, 8'h00));
    tv.push_back(mk(1, 8'hAA, 0, 0, 0, 1, 7'b0000000, 8'h00));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 1, 7'b1100001, 8'h00));
    tv.push_back(mk(1, 8'hFF, 0, 0, 0, 15, 7'b1100001, 8'h00));
    tv.push_back(mk(0, 8'h00, 0, 0, 0, 3, 7'b1010001, 8'h53));
    tv.push_back(mk(0, 8'h00, 0, 0, 1, 1, 7'b1011001, 8'hAA));
    tv.push_back(mk(0, 8'h00, 0, 0, 0, 1, 7'b1011001, 8'hAA));
    tv.push_back(mk(0, 8'h00, 0, 0, 1, 1, 7'b1000101, 8'h00));
    tv.push_back(mk(0, 8'h00, 0, 1, 0, 1, 7'b0000000, 8'h00));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 3, 7'b0000000, 8'h00));
    tv.push_back(mk(0, 8'h00, 0, 1, 1, 2, 7'b0000000, 8'h00));
    foreach (tv[r])
      for (int k = 0; k < tv[r].n; k++) begin
        wr_en = tv[r].we; wr_data = tv[r].wd; send = tv[r].snd;
        abort = tv[r].abt; data_consumed = tv[r].dc;
        tick();
        chk($sformatf("vec%0d.%0d_flags", r, k), fl, tv[r].fl);
        if (tv[r].fl[4]) chk($sformatf("vec%0d.%0d_data", r, k), data, tv[r].d);
      end
    wr_en = 1'b0; send = 1'b0; abort = 1'b0; data_consumed = 1'b0;
    for (int i = 0; i < 64; i++) begin
      chk("wr_full_filling", wr_full, 0);
      wr(8'(i));
    end
    chk("wr_full_at_depth", wr_full, 1);
    wr(8'hFF);
    chk("wr_full_after_drop", wr_full, 1);
    pulse_send();
    play(64, 8'h00);
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
    pulse_send();
    wait_avail();
    repeat (2) begin
      data_consumed = 1'b1;
      tick();
      data_consumed = 1'b0;
    end
    chk("abort_third_byte", data, 8'h12);
    abort = 1'b1; data_consumed = 1'b1;
    tick();
    abort = 1'b0; data_consumed = 1'b0;
    chk("abort_send_flags", fl, 7'b0000010);
    tick();
    chk("abort_pulse_end", fl, 0);
    pulse_send();
    chk("abort_count_cleared", busy, 0);
    wr(8'h21);
    pulse_send();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_preamble_flags", fl, 7'b0000010);
    pulse_send();
    chk("abort_preamble_cleared", busy, 0);
    for (int i = 0; i < 3; i++) wr(8'h40 + 8'(i));
    pulse_send();
    wait_avail();
    reset = 1'b1;
    tick();
    chk("reset_send_flags", fl, 0);
    chk("reset_send_data", data, 0);
    reset = 1'b0;
    wr(8'h77);
    pulse_send();
    play(1, 8'h77);
`ifdef TX_FEEDER_RESEND_EN
    wr(8'h01);
    wr(8'h02);
    pulse_send();
    play(2, 8'h01);
    resend = 1'b1;
    tick();
    resend = 1'b0;
    chk("resend_busy", busy, 1);
    play(2, 8'h01);
    wr(8'h05);
    pulse_send();
    play(1, 8'h05);
`else
    wr(8'h01);
    wr(8'h02);
    pulse_send();
    play(2, 8'h01);
    resend = 1'b1;
    tick();
    resend = 1'b0;
    chk("resend_ignored", busy, 0);
    pulse_send();
    chk("finish_cleared_buffer", busy, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tx_feeder.md
TX_FEEDER -- requirements
Module: tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, frame buffer size in bytes (power of 2, 4..256).
REQ-002 SHALL have parameter PREAMBLE, default 16, number of clk cycles flag_fill is held before the first byte (1..255).
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port wr_data  in  8  host byte to append to the frame.
REQ-006 SHALL have port wr_en  in  1  append wr_data this cycle.
REQ-007 SHALL have port wr_full  out  1  buffer cannot accept a write.
REQ-008 SHALL have port send  in  1  pulse: start transmitting the buffered frame.
REQ-009 SHALL have port abort  in  1  pulse: cancel the frame in progress.
REQ-010 SHALL have port resend  in  1  pulse: replay the last frame (see Configuration).
REQ-011 SHALL have port busy  out  1  high from send acceptance to completion or abort.
REQ-012 SHALL have port done  out  1  one-cycle pulse when the last byte is consumed.
REQ-013 SHALL have port aborted  out  1  one-cycle pulse when an abort is taken.
REQ-014 SHALL have port flag_fill  out  1  to transmitter: send flags.
REQ-015 SHALL have port data  out  8  to transmitter: current byte.
REQ-016 SHALL have port data_available  out  1  to transmitter: data is valid.
REQ-017 SHALL have port data_consumed  in  1  from transmitter: one-cycle pulse, current byte taken.
REQ-018 SHALL have port eop  out  1  to transmitter: the current byte is the last byte of the frame.

Function
REQ-019 SHALL implement the states IDLE, PREAMBLE, SEND and FINISH.
REQ-020 In IDLE, wr_en with count<DEPTH SHALL write mem[wr_ptr] and increment wr_ptr and count.
REQ-021 wr_en when wr_full=1 SHALL drop the byte with no state change.
REQ-022 wr_full SHALL equal (count==DEPTH) OR (state!=IDLE).
REQ-023 send in IDLE with count>0 SHALL set rd_ptr=0, load the preamble counter with PREAMBLE and enter PREAMBLE on the next cycle.
REQ-024 send with count==0, or send outside IDLE, SHALL be ignored.
REQ-025 In PREAMBLE, flag_fill SHALL be 1 and data_available SHALL be 0.
REQ-026 The preamble counter SHALL decrement each cycle; on reaching 0 the block SHALL enter SEND with data=mem[0].
REQ-027 In SEND, flag_fill SHALL be 0 and data_available SHALL be 1.
REQ-028 In SEND, data SHALL be registered and stable until data_consumed.
REQ-029 In SEND, eop SHALL equal (rd_ptr==count-1).
REQ-030 data_consumed in SEND with eop=0 SHALL increment rd_ptr and present the next byte on the following cycle, with data_available staying high.
REQ-031 data_consumed in SEND with eop=1 SHALL enter FINISH, with data_available=0 and eop=0 on the next cycle.
REQ-032 data_consumed outside SEND SHALL be ignored.
REQ-033 FINISH SHALL last one cycle, pulse done, clear count/wr_ptr (subject to Configuration) and return to IDLE.
REQ-034 busy SHALL be 1 in PREAMBLE, SEND and FINISH.
REQ-035 abort in PREAMBLE or SEND SHALL, on the next cycle, drop flag_fill, data_available and eop, pulse aborted, clear count and pointers, and enter IDLE.
REQ-036 abort SHALL win over a simultaneous data_consumed or send.
REQ-037 abort in IDLE or FINISH SHALL be ignored.
REQ-038 A frame of exactly DEPTH bytes SHALL transmit correctly, with pointer width log2(DEPTH) and count width log2(DEPTH)+1.

Reset
REQ-039 reset SHALL force state=IDLE and count=wr_ptr=rd_ptr=0.
REQ-040 reset SHALL force every output to 0 (data=8'h00), except wr_full which SHALL be 0.
REQ-041 reset SHALL take priority over all other inputs, including mid-frame.
REQ-042 Buffer memory contents SHALL NOT be reset.

Configuration
REQ-043 With TX_FEEDER_RESEND_EN defined, FINISH SHALL keep count and clear only rd_ptr.
REQ-044 With TX_FEEDER_RESEND_EN defined, resend in IDLE with count>0 SHALL behave as send.
REQ-045 With TX_FEEDER_RESEND_EN defined, the first wr_en after FINISH SHALL clear count and wr_ptr before writing, starting a new frame.
REQ-046 Without TX_FEEDER_RESEND_EN, resend SHALL be ignored and FINISH SHALL clear the buffer.

Structure
REQ-047 Package eb3_tx_pkg SHALL hold the state enum and default DEPTH/PREAMBLE constants.
REQ-048 Storage SHALL be the sub-module tx_feeder_ram: DEPTH x 8, one write port, one read port.

Verification
REQ-049 Write 8'h53, 8'hAA; send -> flag_fill high 16 cycles; 53 then AA presented; eop with AA only; done 1 cycle after the second consume.
REQ-050 Write 64 bytes 0..63 -> wr_full=1, 65th write dropped; send -> 64 bytes in order; eop on 63.
REQ-051 send with empty buffer -> busy stays 0, no flag_fill.
REQ-052 abort during the third byte of a 5-byte frame -> next cycle data_available=0, aborted pulse, count=0.
REQ-053 reset asserted in SEND -> all outputs 0 next cycle; subsequent write+send works.
REQ-054 With TX_FEEDER_RESEND_EN: frame 01,02 sent; resend -> 01,02 replayed; a write of 05 then send -> only 05 sent.
